spi_slave_shift_engine: RTL and testbench

- Pin-level SPI slave serialiser/deserialiser, oversampled on the system clock.
- Consumes SCLK/CS/MOSI from the bus and produces MISO toward the bus, alongside slave_driver_bfm.
- Exchanges parallel characters with the slave-side data path over valid/ready handshakes.
- Serves as the reference slave model and synthesizable slave endpoint for the AVIP loopback environment.

---
 rtl/spi_slave_shift_engine_pkg.sv | 13 +
 rtl/spi_slave_shift_engine_sync.sv | 40 ++++
 rtl/spi_slave_shift_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_spi_slave_shift_engine.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_shift_engine_pkg.sv
// Shared state type and constants for the SPI slave shift engine.
package spi_slave_engine_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      ACTIVE = 2'd2
   } slave_engine_state_e;

   localparam int unsigned SYNC_STAGES   = 2;
   localparam logic        IDLE_FILL_BIT = 1'b1;

endpackage

// File: rtl/spi_slave_shift_engine_sync.sv
// Two-flop synchroniser for one asynchronous bus pin, with registered
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge_detect
   import spi_slave_engine_pkg::*;
#(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rise_q;
   logic                   fall_q;

   // Synchroniser chain plus one history flop for edge detection.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q <= {SYNC_STAGES{RESET_VAL}};
         prev_q <= RESET_VAL;
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
         rise_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
         fall_q <= ~sync_q[SYNC_STAGES-1] & prev_q;
      end
   end

   assign q_o    = sync_q[SYNC_STAGES-1];
   assign rise_o = rise_q;
   assign fall_o = fall_q;

endmodule

// File: rtl/spi_slave_shift_engine.sv
// Oversampled SPI slave serialiser/deserialiser with valid/ready character ports.
// Optional macro SPI_SLAVE_RX_OVERRUN_EN: keep old rx char and pulse rx_overrun instead of overwriting.
module spi_slave_shift_engine
   import spi_slave_engine_pkg::*;
#(
   parameter int unsigned             CHAR_LENGTH = 8,
   parameter logic [CHAR_LENGTH-1:0]  IDLE_FILL   = {CHAR_LENGTH{IDLE_FILL_BIT}}
) (
   input  logic                   pclk,
   input  logic                   areset,
   input  logic                   sclk,
   input  logic                   cs_n,
   input  logic                   mosi0,
   output logic                   miso0,
   output logic                   miso_oe,
   input  logic                   cpol,
   input  logic                   cpha,
   input  logic                   msb_first,
   input  logic [CHAR_LENGTH-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic [CHAR_LENGTH-1:0] rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   frame_abort,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
   output logic                   rx_overrun,
`endif
   output logic                   tx_underrun
);

   localparam int unsigned CW = $clog2(CHAR_LENGTH);

   logic sclk_rise_s, sclk_fall_s, cs_s, cs_fall_s, cs_rise_s, mosi_s, mosi_rise_s, mosi_fall_s;
   logic [2:0] unused_edges_s;

   spi_sync_edge_detect #(.RESET_VAL(1'b0)) u_sync_sclk (
      .clk_i(pclk), .rst_i(areset), .d_i(sclk),
      .q_o(), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
   );
   spi_sync_edge_detect #(.RESET_VAL(1'b1)) u_sync_cs (
      .clk_i(pclk), .rst_i(areset), .d_i(cs_n),
      .q_o(cs_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
   );
   spi_sync_edge_detect #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk_i(pclk), .rst_i(areset), .d_i(mosi0),
      .q_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
   );
   assign unused_edges_s = {cs_rise_s, mosi_rise_s, mosi_fall_s};

   slave_engine_state_e    state_q, state_d;
   logic                   cpol_q, cpol_d, cpha_q, cpha_d, msb_q, msb_d;
   logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [CHAR_LENGTH-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d, miso_q, miso_d, miso_oe_q, miso_oe_d;
   logic                   tx_ready_q, tx_ready_d, tx_underrun_q, tx_underrun_d;
   logic                   frame_abort_q, frame_abort_d;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
   logic                   rx_overrun_q, rx_overrun_d;
`endif
   logic                   lead_s, trail_s, sample_s, shift_s, complete_s;
   logic [CHAR_LENGTH-1:0] rx_next_s, tx_load_s;

   function automatic logic first_bit(input logic [CHAR_LENGTH-1:0] c, input logic msb);
      first_bit = msb ? c[CHAR_LENGTH-1] : c[0];
   endfunction

   function automatic logic [CHAR_LENGTH-1:0] shift_out(input logic [CHAR_LENGTH-1:0] c, input logic msb);
      shift_out = msb ? {c[CHAR_LENGTH-2:0], 1'b1} : {1'b1, c[CHAR_LENGTH-1:1]};
   endfunction

   // Next-state logic for the frame FSM, shifters and handshakes.
   always_comb begin
      lead_s        = cpol_q ? sclk_fall_s : sclk_rise_s;
      trail_s       = cpol_q ? sclk_rise_s : sclk_fall_s;
      sample_s      = cpha_q ? trail_s : lead_s;
      shift_s       = cpha_q ? lead_s : trail_s;
      rx_next_s     = msb_q ? {rx_sh_q[CHAR_LENGTH-2:0], mosi_s} : {mosi_s, rx_sh_q[CHAR_LENGTH-1:1]};
      tx_load_s     = tx_valid ? tx_data : IDLE_FILL;
      complete_s    = 1'b0;
      state_d       = state_q;
      cpol_d        = cpol_q;
      cpha_d        = cpha_q;
      msb_d         = msb_q;
      bit_cnt_d     = bit_cnt_q;
      tx_sh_d       = tx_sh_q;
      rx_sh_d       = rx_sh_q;
      rx_data_d     = rx_data_q;
      miso_d        = miso_q;
      miso_oe_d     = ~cs_s;
      tx_ready_d    = 1'b0;
      tx_underrun_d = 1'b0;
      frame_abort_d = 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      rx_overrun_d  = 1'b0;
`endif
      unique case (state_q)
         IDLE: begin
            miso_d    = 1'b1;
            bit_cnt_d = '0;
            if (cs_fall_s) begin
               cpol_d  = cpol;
               cpha_d  = cpha;
               msb_d   = msb_first;
               state_d = LOAD;
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: begin
            tx_ready_d    = tx_valid;
            tx_underrun_d = ~tx_valid;
            bit_cnt_d     = '0;
            state_d       = ACTIVE;
            if (!cpha_q) begin
               miso_d  = first_bit(tx_load_s, msb_q);
               tx_sh_d = shift_out(tx_load_s, msb_q);
            end else begin
               tx_sh_d = tx_load_s;
            end
         end
         ACTIVE: begin
            if (cs_s) begin
               state_d       = IDLE;
               miso_d        = 1'b1;
               frame_abort_d = (bit_cnt_q != '0);
            end else begin
               // In CPHA=0 the trailing edge of the previous character's last bit lands here with count 0.
               if (shift_s && (cpha_q || bit_cnt_q != '0)) begin
                  miso_d  = first_bit(tx_sh_q, msb_q);
                  tx_sh_d = shift_out(tx_sh_q, msb_q);
               end else begin
                  tx_sh_d = tx_sh_q;
               end
               if (sample_s) begin
                  rx_sh_d = rx_next_s;
                  if (bit_cnt_q == CW'(CHAR_LENGTH - 1)) begin
                     complete_s = 1'b1;
                     bit_cnt_d  = '0;
                     state_d    = LOAD;
                  end else begin
                     bit_cnt_d = bit_cnt_q + CW'(1);
                  end
               end else begin
                  rx_sh_d = rx_sh_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
            miso_d  = 1'b1;
         end
      endcase
      rx_valid_d = (rx_valid_q && rx_ready) ? 1'b0 : rx_valid_q;
      if (complete_s) begin
`ifdef SPI_SLAVE_RX_OVERRUN_EN
         if (rx_valid_q && !rx_ready) begin
            rx_overrun_d = 1'b1;
         end else begin
            rx_data_d  = rx_next_s;
            rx_valid_d = 1'b1;
         end
`else
         rx_data_d  = rx_next_s;
         rx_valid_d = 1'b1;
`endif
      end else begin
         rx_data_d = rx_data_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (areset) begin
         state_q       <= IDLE;
         cpol_q        <= 1'b0;
         cpha_q        <= 1'b0;
         msb_q         <= 1'b1;
         bit_cnt_q     <= '0;
         tx_sh_q       <= '0;
         rx_sh_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         miso_q        <= 1'b1;
         miso_oe_q     <= 1'b0;
         tx_ready_q    <= 1'b0;
         tx_underrun_q <= 1'b0;
         frame_abort_q <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
         rx_overrun_q  <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         cpol_q        <= cpol_d;
         cpha_q        <= cpha_d;
         msb_q         <= msb_d;
         bit_cnt_q     <= bit_cnt_d;
         tx_sh_q       <= tx_sh_d;
         rx_sh_q       <= rx_sh_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         miso_q        <= miso_d;
         miso_oe_q     <= miso_oe_d;
         tx_ready_q    <= tx_ready_d;
         tx_underrun_q <= tx_underrun_d;
         frame_abort_q <= frame_abort_d;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
         rx_overrun_q  <= rx_overrun_d;
`endif
      end
   end

   assign miso0       = miso_q;
   assign miso_oe     = miso_oe_q;
   assign tx_ready    = tx_ready_q;
   assign tx_underrun = tx_underrun_q;
   assign frame_abort = frame_abort_q;
   assign rx_data     = rx_data_q;
   assign rx_valid    = rx_valid_q;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
   assign rx_overrun  = rx_overrun_q;
`endif

endmodule

// File: tb/tb_spi_slave_shift_engine.sv
// Scoreboard bench for spi_slave_shift_engine: a behavioural SPI master drives the pins at pclk/8.
module tb_spi_slave_shift_engine;

   logic       pclk = 1'b0;
   logic       areset, sclk, cs_n, mosi0, cpol, cpha, msb_first;
   logic       miso0, miso_oe, tx_ready, tx_valid, rx_valid, rx_ready, frame_abort, tx_underrun;
   logic [7:0] tx_data, rx_data;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
   logic       rx_overrun;
`endif

   int checks = 0;
   int failures = 0;
   int n_tx_ready = 0, n_underrun = 0, n_abort = 0, n_overrun = 0;
   int rd_idx = 0;

   logic [7:0] rx_got_q [$];
   logic [7:0] exp_rx_q [$];
   logic [7:0] exp_miso_q [$];
   logic [7:0] mos [0:1];
   logic [7:0] got [0:1];
   logic [7:0] txd [0:2];
   logic       txv [0:2];
   logic       mcpol, mcpha, mmsb;

   always #5 pclk = ~pclk;

   spi_slave_shift_engine dut (
      .pclk(pclk), .areset(areset), .sclk(sclk), .cs_n(cs_n), .mosi0(mosi0),
      .miso0(miso0), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha), .msb_first(msb_first),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .frame_abort(frame_abort),
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      .rx_overrun(rx_overrun),
`endif
      .tx_underrun(tx_underrun)
   );

   // Passive monitor: collects accepted rx characters and counts pulses.
   always @(negedge pclk) begin
      if (rx_valid && rx_ready) rx_got_q.push_back(rx_data);
      if (tx_ready) n_tx_ready++;
      if (tx_underrun) n_underrun++;
      if (frame_abort) n_abort++;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      if (rx_overrun) n_overrun++;
`endif
   end

   // Behavioural master: nch characters, stop after nbits total bits, optionally release CS.
   task automatic spi_frame(input int nch, input int nbits, input bit raise);
      int bi;
      cpol = mcpol; cpha = mcpha; msb_first = mmsb;
      sclk = mcpol;
      tx_data = txd[0]; tx_valid = txv[0];
      @(negedge pclk);
      cs_n = 1'b0;
      repeat (8) @(negedge pclk);
      for (int c = 0; c < nch; c++) begin
         got[c] = 8'h00;
         for (int i = 0; i < 8; i++) begin
            bi = mmsb ? 7 - i : i;
            if (c * 8 + i < nbits) begin
               if (!mcpha) begin
                  mosi0 = mos[c][bi];
                  repeat (4) @(negedge pclk);
                  sclk = ~mcpol;
                  got[c][bi] = miso0;
                  repeat (4) @(negedge pclk);
                  sclk = mcpol;
               end else begin
                  repeat (4) @(negedge pclk);
                  sclk = ~mcpol;
                  mosi0 = mos[c][bi];
                  repeat (4) @(negedge pclk);
                  sclk = mcpol;
                  got[c][bi] = miso0;
               end
               if (i == 3) begin
                  tx_data = txd[c+1];
                  tx_valid = txv[c+1];
               end
            end
         end
      end
      repeat (4) @(negedge pclk);
      if (raise) begin
         cs_n = 1'b1;
         repeat (8) @(negedge pclk);
      end
   endtask

   task automatic test_reset();
      areset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi0 = 1'b0; cpol = 1'b0; cpha = 1'b0;
      msb_first = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b1;
      repeat (5) @(negedge pclk);
      areset = 1'b0;
      repeat (3) @(negedge pclk);
      checks++; if (miso0 !== 1'b1) begin failures++; $display("FAIL reset_miso0 got=%b exp=1", miso0); end
      checks++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso_oe got=%b exp=0", miso_oe); end
      checks++; if (tx_ready !== 1'b0 || tx_underrun !== 1'b0 || frame_abort !== 1'b0) begin
         failures++; $display("FAIL reset_pulses got=%b%b%b exp=000", tx_ready, tx_underrun, frame_abort); end
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
      checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
   endtask

   task automatic test_mode0_msb();
      int b_tx = n_tx_ready;
      int b_un = n_underrun;
      mcpol = 1'b0; mcpha = 1'b0; mmsb = 1'b1;
      mos[0] = 8'h3C; txd[0] = 8'hA5; txv[0] = 1'b1; txd[1] = 8'h00; txv[1] = 1'b0;
      exp_rx_q.push_back(8'h3C); exp_miso_q.push_back(8'hA5);
      spi_frame(1, 8, 1'b1);
      checks++; if (got[0] !== exp_miso_q[0]) begin failures++; $display("FAIL m0_miso got=%h exp=%h", got[0], exp_miso_q[0]); end
      void'(exp_miso_q.pop_front());
      checks++; if (rx_got_q.size() <= rd_idx || rx_got_q[rd_idx] !== exp_rx_q[0]) begin
         failures++; $display("FAIL m0_rx got_n=%0d exp=%h", rx_got_q.size() - rd_idx, exp_rx_q[0]); end
      rd_idx++; void'(exp_rx_q.pop_front());
      checks++; if (n_tx_ready - b_tx !== 1) begin failures++; $display("FAIL m0_tx_ready got=%0d exp=1", n_tx_ready - b_tx); end
      checks++; if (n_underrun - b_un !== 1) begin failures++; $display("FAIL m0_underrun got=%0d exp=1", n_underrun - b_un); end
      checks++; if (miso_oe !== 1'b0 || miso0 !== 1'b1) begin
         failures++; $display("FAIL m0_deselect got oe=%b miso=%b exp oe=0 miso=1", miso_oe, miso0); end
   endtask

   task automatic test_mode3_lsb_b2b();
      int b_tx = n_tx_ready;
      mcpol = 1'b1; mcpha = 1'b1; mmsb = 1'b0;
      mos[0] = 8'hF0; mos[1] = 8'h0F;
      txd[0] = 8'h01; txv[0] = 1'b1; txd[1] = 8'h80; txv[1] = 1'b1; txd[2] = 8'h00; txv[2] = 1'b0;
      exp_rx_q.push_back(8'hF0); exp_rx_q.push_back(8'h0F);
      exp_miso_q.push_back(8'h01); exp_miso_q.push_back(8'h80);
      spi_frame(2, 16, 1'b1);
      for (int c = 0; c < 2; c++) begin
         checks++; if (got[c] !== exp_miso_q[0]) begin failures++; $display("FAIL m3_miso%0d got=%h exp=%h", c, got[c], exp_miso_q[0]); end
         void'(exp_miso_q.pop_front());
         checks++; if (rx_got_q.size() <= rd_idx || rx_got_q[rd_idx] !== exp_rx_q[0]) begin
            failures++; $display("FAIL m3_rx%0d got_n=%0d exp=%h", c, rx_got_q.size() - rd_idx, exp_rx_q[0]); end
         rd_idx++; void'(exp_rx_q.pop_front());
      end
      checks++; if (n_tx_ready - b_tx !== 2) begin failures++; $display("FAIL m3_tx_ready got=%0d exp=2", n_tx_ready - b_tx); end
   endtask

   task automatic test_underrun();
      int b_un = n_underrun;
      mcpol = 1'b0; mcpha = 1'b1; mmsb = 1'b1;
      mos[0] = 8'h5A; txd[0] = 8'h33; txv[0] = 1'b0; txd[1] = 8'h00; txv[1] = 1'b0;
      exp_rx_q.push_back(8'h5A); exp_miso_q.push_back(8'hFF);
      spi_frame(1, 8, 1'b1);
      checks++; if (got[0] !== exp_miso_q[0]) begin failures++; $display("FAIL un_miso got=%h exp=%h", got[0], exp_miso_q[0]); end
      void'(exp_miso_q.pop_front());
      checks++; if (rx_got_q.size() <= rd_idx || rx_got_q[rd_idx] !== exp_rx_q[0]) begin
         failures++; $display("FAIL un_rx got_n=%0d exp=%h", rx_got_q.size() - rd_idx, exp_rx_q[0]); end
      rd_idx++; void'(exp_rx_q.pop_front());
      checks++; if (n_underrun - b_un !== 2) begin failures++; $display("FAIL un_pulses got=%0d exp=2", n_underrun - b_un); end
   endtask

   task automatic test_abort();
      int b_ab = n_abort;
      int b_rx = rx_got_q.size();
      mcpol = 1'b0; mcpha = 1'b0; mmsb = 1'b1;
      mos[0] = 8'hE7; txd[0] = 8'h00; txv[0] = 1'b0; txd[1] = 8'h00; txv[1] = 1'b0;
      spi_frame(1, 5, 1'b1);
      checks++; if (n_abort - b_ab !== 1) begin failures++; $display("FAIL ab_pulse got=%0d exp=1", n_abort - b_ab); end
      checks++; if (rx_valid !== 1'b0 || rx_got_q.size() !== b_rx) begin
         failures++; $display("FAIL ab_no_rx got valid=%b n=%0d exp valid=0 n=%0d", rx_valid, rx_got_q.size(), b_rx); end
      mcpol = 1'b1; mcpha = 1'b0; mmsb = 1'b1;
      mos[0] = 8'hC3; txd[0] = 8'h96; txv[0] = 1'b1;
      exp_rx_q.push_back(8'hC3); exp_miso_q.push_back(8'h96);
      spi_frame(1, 8, 1'b1);
      checks++; if (got[0] !== exp_miso_q[0]) begin failures++; $display("FAIL ab_next_miso got=%h exp=%h", got[0], exp_miso_q[0]); end
      void'(exp_miso_q.pop_front());
      checks++; if (rx_got_q.size() <= rd_idx || rx_got_q[rd_idx] !== exp_rx_q[0]) begin
         failures++; $display("FAIL ab_next_rx got_n=%0d exp=%h", rx_got_q.size() - rd_idx, exp_rx_q[0]); end
      rd_idx++; void'(exp_rx_q.pop_front());
      checks++; if (n_abort - b_ab !== 1) begin failures++; $display("FAIL ab_no_extra got=%0d exp=1", n_abort - b_ab); end
   endtask

   task automatic test_overrun();
      int b_ov = n_overrun;
      mcpol = 1'b0; mcpha = 1'b0; mmsb = 1'b1;
      mos[0] = 8'h11; mos[1] = 8'h22; txv[0] = 1'b0; txv[1] = 1'b0; txv[2] = 1'b0;
      @(posedge pclk); #1 rx_ready = 1'b0;
      spi_frame(2, 16, 1'b1);
`ifdef SPI_SLAVE_RX_OVERRUN_EN
      exp_rx_q.push_back(8'h11);
      checks++; if (n_overrun - b_ov !== 1) begin failures++; $display("FAIL ov_pulse got=%0d exp=1", n_overrun - b_ov); end
`else
      exp_rx_q.push_back(8'h22);
      checks++; if (n_overrun - b_ov !== 0) begin failures++; $display("FAIL ov_pulse got=%0d exp=0", n_overrun - b_ov); end
`endif
      checks++; if (rx_valid !== 1'b1) begin failures++; $display("FAIL ov_valid_held got=%b exp=1", rx_valid); end
      checks++; if (rx_data !== exp_rx_q[0]) begin failures++; $display("FAIL ov_rx_data got=%h exp=%h", rx_data, exp_rx_q[0]); end
      @(posedge pclk); #1 rx_ready = 1'b1;
      repeat (3) @(negedge pclk);
      checks++; if (rx_got_q.size() <= rd_idx || rx_got_q[rd_idx] !== exp_rx_q[0]) begin
         failures++; $display("FAIL ov_drain got_n=%0d exp=%h", rx_got_q.size() - rd_idx, exp_rx_q[0]); end
      rd_idx++; void'(exp_rx_q.pop_front());
      checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL ov_valid_drop got=%b exp=0", rx_valid); end
   endtask

   task automatic test_reset_midframe();
      int b_ab = n_abort;
      int b_rx = rx_got_q.size();
      mcpol = 1'b0; mcpha = 1'b0; mmsb = 1'b1;
      mos[0] = 8'h99; txd[0] = 8'h42; txv[0] = 1'b1; txd[1] = 8'h00; txv[1] = 1'b0;
      spi_frame(1, 3, 1'b0);
      areset = 1'b1;
      @(posedge pclk); #1;
      checks++; if (miso_oe !== 1'b0 || miso0 !== 1'b1) begin
         failures++; $display("FAIL rst_mid_pins got oe=%b miso=%b exp oe=0 miso=1", miso_oe, miso0); end
      cs_n = 1'b1; tx_valid = 1'b0;
      repeat (5) @(negedge pclk);
      areset = 1'b0;
      repeat (6) @(negedge pclk);
      checks++; if (rx_data !== 8'h00 || rx_valid !== 1'b0) begin
         failures++; $display("FAIL rst_mid_rx got data=%h valid=%b exp data=00 valid=0", rx_data, rx_valid); end
      checks++; if (n_abort - b_ab !== 0 || rx_got_q.size() !== b_rx) begin
         failures++; $display("FAIL rst_mid_quiet got abort=%0d rx=%0d exp 0 0", n_abort - b_ab, rx_got_q.size() - b_rx); end
      mos[0] = 8'h6B; txd[0] = 8'hD2; txv[0] = 1'b1;
      exp_rx_q.push_back(8'h6B); exp_miso_q.push_back(8'hD2);
      spi_frame(1, 8, 1'b1);
      checks++; if (got[0] !== exp_miso_q[0]) begin failures++; $display("FAIL rst_next_miso got=%h exp=%h", got[0], exp_miso_q[0]); end
      void'(exp_miso_q.pop_front());
      checks++; if (rx_got_q.size() <= rd_idx || rx_got_q[rd_idx] !== exp_rx_q[0]) begin
         failures++; $display("FAIL rst_next_rx got_n=%0d exp=%h", rx_got_q.size() - rd_idx, exp_rx_q[0]); end
      rd_idx++; void'(exp_rx_q.pop_front());
   endtask

   initial begin
      test_reset();
      test_mode0_msb();
      test_mode3_lsb_b2b();
      test_underrun();
      test_abort();
      test_overrun();
      test_reset_midframe();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
